// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-line round-robin grant arbiter.
// Pure declarations; no timing or flow control of its own.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;
  localparam logic [NREQ-1:0] GNT_NONE = '0;

  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: one-hot of the first set req bit at or after ptr.
// Combinational, zero latency; no flow control.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] pick,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    pick = GNT_NONE;
    idx  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && (pick == GNT_NONE)) pick[idx] = 1'b1;
    end
    any = |req;
  end

endmodule

// File: rtl/rr_grant_arbiter4.sv
// Round-robin 4-line arbiter with registered one-hot grant; req to gnt is 1 cycle.
// A grant is held until done, request withdrawal or hold timeout, then one idle gap cycle.
module rr_grant_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       pick;
  logic             any;
  logic             release_now;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  // done wins over withdrawal, which wins over timeout; only a pure timeout flags.
  assign release_now = done || !req[owner_q] || (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = GNT_NONE;
        if (any) begin
          gnt_d   = pick;
          owner_d = onehot_to_idx(pick);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d     = GNT_NONE;
          state_d   = IDLE;
          ptr_d     = owner_q + 2'd1;
          cnt_d     = '0;
          timeout_d = !done && req[owner_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= GNT_NONE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Directed-vector bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_rr_grant_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int         tgt;
    logic [3:0] g;
    logic       t;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;

  rr_grant_arbiter4 #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: invariants every cycle, plus any expectation targeted at this cycle.
  always @(negedge clk) begin
    total++;
    if (!$onehot0(gnt) || (gnt_valid != (gnt != 4'b0000))) begin
      bad++;
      $display("FAIL invariant cyc=%0d gnt=%b gnt_valid=%b", cyc, gnt, gnt_valid);
    end
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.tgt != cyc) begin
        bad++;
        $display("FAIL %s missed target cyc=%0d now=%0d", e.name, e.tgt, cyc);
      end else if (gnt !== e.g || timeout !== e.t || gnt_valid !== (e.g != 4'b0000)) begin
        bad++;
        $display("FAIL %s cyc=%0d got gnt=%b to=%b vld=%b want gnt=%b to=%b",
                 e.name, cyc, gnt, timeout, gnt_valid, e.g, e.t);
      end
    end
  end

  task automatic step(input string nm, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic et);
    exp_t x;
    req    = r;
    done   = d;
    x.tgt  = cyc + 1;
    x.g    = eg;
    x.t    = et;
    x.name = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input string nm, input logic [3:0] eg);
    total++;
    if (gnt !== eg || gnt_valid !== (eg != 4'b0000) || timeout !== 1'b0) begin
      bad++;
      $display("FAIL %s got gnt=%b vld=%b to=%b want gnt=%b to=0",
               nm, gnt, gnt_valid, timeout, eg);
    end
  endtask

  logic [3:0] rr_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset_state", 4'b0000);
    rst_n = 1'b1;

    // Single request on line 2, done in third grant cycle; ptr must land on 3.
    step("t1_grant", 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("t1_hold1", 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("t1_hold2", 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("t1_done",  4'b0100, 1'b1, 4'b0000, 1'b0);
    step("t1_idle",  4'b0000, 1'b0, 4'b0000, 1'b0);
    step("t1_ptr3",  4'b1111, 1'b0, 4'b1000, 1'b0);
    step("t1_rel3",  4'b1111, 1'b1, 4'b0000, 1'b0);

    // All four requesting, done on every second grant cycle.
    for (int i = 0; i < 4; i++) begin
      step("t2_grant", 4'b1111, 1'b0, rr_seq[i], 1'b0);
      step("t2_hold",  4'b1111, 1'b0, rr_seq[i], 1'b0);
      step("t2_gap",   4'b1111, 1'b1, 4'b0000, 1'b0);
    end
    step("t2_wrap", 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("t2_drop", 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("t2_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Timeout: line 1 held 15 cycles, one-cycle timeout pulse on release.
    step("t3_grant", 4'b0010, 1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 14; i++) step("t3_hold", 4'b0010, 1'b0, 4'b0010, 1'b0);
    step("t3_timeout", 4'b0010, 1'b0, 4'b0000, 1'b1);
    step("t3_after",   4'b0000, 1'b0, 4'b0000, 1'b0);

    // done coincides with the timeout cycle: plain release, no pulse; ptr 2 -> 3.
    step("t4_grant", 4'b0100, 1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 14; i++) step("t4_hold", 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("t4_done_to", 4'b0100, 1'b1, 4'b0000, 1'b0);
    step("t4_ptr3",    4'b1111, 1'b0, 4'b1000, 1'b0);
    step("t4_rel3",    4'b1111, 1'b1, 4'b0000, 1'b0);

    // Owner 2 withdraws mid-grant; other lines toggling are ignored meanwhile.
    step("t5_grant",   4'b0100, 1'b0, 4'b0100, 1'b0);
    step("t5_noise",   4'b1111, 1'b0, 4'b0100, 1'b0);
    step("t5_withdr",  4'b0011, 1'b0, 4'b0000, 1'b0);
    step("t5_ptr3",    4'b1111, 1'b0, 4'b1000, 1'b0);
    step("t5_rel3",    4'b1111, 1'b1, 4'b0000, 1'b0);

    // Advance ptr to 2, grant line 2, then reset between edges.
    step("t6_g1",   4'b0010, 1'b0, 4'b0010, 1'b0);
    step("t6_r1",   4'b0010, 1'b1, 4'b0000, 1'b0);
    step("t6_g2",   4'b1111, 1'b0, 4'b0100, 1'b0);
    step("t6_h2",   4'b1111, 1'b0, 4'b0100, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk_now("t6_async_clr", 4'b0000);
    @(posedge clk);
    #1;
    chk_now("t6_in_reset", 4'b0000);
    rst_n = 1'b1;
    step("t6_first0", 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("t6_rel0",   4'b1111, 1'b1, 4'b0000, 1'b0);
    step("t6_next1",  4'b1111, 1'b0, 4'b0010, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
